// File: rtl/mem_seq.sv
// mem_seq: byte-burst memory sequencer with read/write handshakes, abort and address wrap.
module mem_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        write,
    input  logic [15:0] addr_start,
    input  logic [7:0]  len,
    input  logic        abort,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] addr_out,
    output logic        bus_dir,
    output logic        load_main,
    output logic        assert_main,
    output logic [7:0]  main_out,
    input  logic [7:0]  mem_data
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  count_q, count_d;
    logic        rd_mode, wr_mode, beat;

    assign rd_mode = state_q == RD;
    assign wr_mode = state_q == WR;
    assign beat    = (rd_mode && rd_ready) || (wr_mode && wr_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            count_q <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    // An aborted beat is still written to memory but never advances the address.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (start && !abort) begin
                if (len == 8'h00) state_d = DONE;
                else begin
                    addr_d  = addr_start;
                    count_d = len;
                    state_d = write ? WR : RD;
                end
            end
            RD, WR: if (abort) state_d = IDLE;
            else if (beat) begin
                addr_d  = addr_q + 16'h0001;
                count_d = count_q - 8'h01;
                state_d = (count_q == 8'h01) ? DONE : state_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_out    = addr_q;
        busy        = rd_mode || wr_mode;
        done        = state_q == DONE;
        bus_dir     = !wr_mode;
        assert_main = !rd_mode;
        rd_valid    = rd_mode;
        rd_data     = rd_mode ? mem_data : 8'h00;
        wr_ready    = wr_mode;
        main_out    = wr_mode ? wr_data : 8'h00;
        load_main   = !(wr_mode && wr_valid);
    end
endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq: directed bursts against a memory model; a negedge monitor checks beats against a scoreboard.
module tb_mem_seq;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, write = 1'b0, abort = 1'b0;
    logic        wr_valid = 1'b0, rd_ready = 1'b0;
    logic [15:0] addr_start = 16'h0;
    logic [7:0]  len = 8'h0, wr_data = 8'h0;
    logic        wr_ready, rd_valid, busy, done, bus_dir, load_main, assert_main;
    logic [7:0]  rd_data, main_out, mem_data;
    logic [15:0] addr_out;

    mem_seq dut (
        .clk(clk), .reset(reset), .start(start), .write(write), .addr_start(addr_start),
        .len(len), .abort(abort), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy), .done(done),
        .addr_out(addr_out), .bus_dir(bus_dir), .load_main(load_main),
        .assert_main(assert_main), .main_out(main_out), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk) if (load_main === 1'b0) mem[addr_out] <= main_out;
    assign mem_data = assert_main ? 8'h00 : mem[addr_out];

    typedef struct {logic [1:0] k; logic [15:0] a; logic [7:0] d;} ev_t;
    localparam logic [1:0] EW = 2'd0, ER = 2'd1, ED = 2'd2;
    ev_t q[$];
    int tests = 0, fails = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [15:0] a, input logic [7:0] d);
        q.push_back('{k, a, d});
    endtask

    task automatic got(input logic [1:0] k, input logic [15:0] a, input logic [7:0] d);
        ev_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind %0d addr %0h data %0h expected none", k, a, d);
        end else begin
            e = q.pop_front();
            if (e.k !== k || e.a !== a || e.d !== d) begin
                fails++;
                $display("FAIL event: got kind %0d addr %0h data %0h expected kind %0d addr %0h data %0h",
                         k, a, d, e.k, e.a, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (load_main === 1'b0) got(EW, addr_out, main_out);
        if (rd_valid === 1'b1 && rd_ready) got(ER, addr_out, rd_data);
        if (done === 1'b1) got(ED, 16'h0, 8'h0);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic w, input logic [15:0] a, input logic [7:0] l);
        start = 1'b1; write = w; addr_start = a; len = l;
        tick;
        start = 1'b0;
    endtask

    logic [7:0]  b3 [3] = '{8'hAA, 8'hBB, 8'hCC};
    logic [7:0]  b4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic        rp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] ra [5] = '{16'h1000, 16'h1001, 16'h1001, 16'h1002, 16'h1002};

    initial begin
        tick; tick;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_addr", addr_out, 0);
        chk("rst_strobes", {bus_dir, load_main, assert_main, wr_ready, rd_valid}, 5'b11100);
        chk("rst_data", {rd_data, main_out}, 0);
        reset = 1'b0;
        // write burst AA,BB,CC at 0x1000
        push(EW, 16'h1000, 8'hAA); push(EW, 16'h1001, 8'hBB); push(EW, 16'h1002, 8'hCC); push(ED, 0, 0);
        go(1'b1, 16'h1000, 8'd3);
        chk("wr_mode", {bus_dir, wr_ready, assert_main, busy}, 4'b0111);
        foreach (b3[i]) begin wr_valid = 1'b1; wr_data = b3[i]; tick; end
        wr_valid = 1'b0;
        chk("wr_done", done, 1); chk("wr_done_addr", addr_out, 16'h1003);
        tick;
        chk("wr_idle", {done, busy}, 0);
        chk("wr_mem", {mem[16'h1000], mem[16'h1001], mem[16'h1002]}, 24'hAABBCC);
        // read back with rd_ready toggling; a stray start mid-burst must be ignored
        push(ER, 16'h1000, 8'hAA); push(ER, 16'h1001, 8'hBB); push(ER, 16'h1002, 8'hCC); push(ED, 0, 0);
        go(1'b0, 16'h1000, 8'd3);
        for (int i = 0; i < 5; i++) begin
            rd_ready = rp[i];
            start = (i == 1); write = 1'b1; addr_start = 16'h5555; len = 8'd9;
            chk("rd_addr", addr_out, ra[i]);
            tick;
        end
        start = 1'b0; rd_ready = 1'b0;
        chk("rd_done", done, 1);
        tick;
        // address wrap
        push(EW, 16'hFFFE, 8'h11); push(EW, 16'hFFFF, 8'h22); push(EW, 16'h0000, 8'h33); push(EW, 16'h0001, 8'h44);
        push(ED, 0, 0);
        go(1'b1, 16'hFFFE, 8'd4);
        foreach (b4[i]) begin wr_valid = 1'b1; wr_data = b4[i]; tick; end
        wr_valid = 1'b0;
        chk("wrap_done_addr", addr_out, 16'h0002); chk("wrap_done", done, 1);
        chk("wrap_mem", {mem[16'h0000], mem[16'h0001]}, 16'h3344);
        tick;
        // empty burst
        push(ED, 0, 0);
        go(1'b1, 16'h4000, 8'd0);
        chk("len0_done", done, 1); chk("len0_busy", busy, 0); chk("len0_load", load_main, 1);
        tick;
        chk("len0_after", {done, busy}, 0);
        // abort after two beats, no coincident beat
        push(EW, 16'h2000, 8'h01); push(EW, 16'h2001, 8'h02);
        go(1'b1, 16'h2000, 8'd5);
        wr_valid = 1'b1; wr_data = 8'h01; tick;
        wr_data = 8'h02; tick;
        wr_valid = 1'b0; abort = 1'b1; tick;
        abort = 1'b0;
        chk("abort_idle", {busy, done}, 0); chk("abort_addr", addr_out, 16'h2002);
        tick;
        chk("abort_nodone", done, 0);
        // abort coinciding with a write beat: byte written, address held
        push(EW, 16'h3000, 8'h0A); push(EW, 16'h3001, 8'h0B);
        go(1'b1, 16'h3000, 8'd5);
        wr_valid = 1'b1; wr_data = 8'h0A; tick;
        wr_data = 8'h0B; abort = 1'b1; tick;
        abort = 1'b0; wr_valid = 1'b0;
        chk("cabort_busy", busy, 0); chk("cabort_addr", addr_out, 16'h3001);
        chk("cabort_mem", mem[16'h3001], 8'h0B);
        // next start accepted after abort
        push(ER, 16'h2000, 8'h01); push(ED, 0, 0);
        go(1'b0, 16'h2000, 8'd1);
        rd_ready = 1'b1; tick;
        rd_ready = 1'b0;
        chk("restart_done", done, 1);
        tick;
        // abort beats start in IDLE
        abort = 1'b1; start = 1'b1; write = 1'b1; addr_start = 16'h6000; len = 8'd2;
        tick;
        abort = 1'b0; start = 1'b0;
        chk("idle_abort_busy", busy, 0); chk("idle_abort_addr", addr_out, 16'h2001);
        tick;
        chk("idle_abort_done", done, 0);
        // reset mid-read with count=3
        push(ER, 16'h1000, 8'hAA); push(ER, 16'h1001, 8'hBB);
        go(1'b0, 16'h1000, 8'd5);
        rd_ready = 1'b1; tick; tick;
        rd_ready = 1'b0; reset = 1'b1; tick;
        reset = 1'b0;
        chk("mrst_state", {busy, done, rd_valid, assert_main, load_main}, 5'b00011);
        chk("mrst_addr", addr_out, 16'h0000);
        tick;
        chk("mrst_after", {busy, done}, 0);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
